// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-CBC chaining controller.
package aes_pkg;

    localparam int unsigned BLOCK_W            = 128;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 63;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // Result beat presented on the output handshake.
    typedef struct packed {
        logic   last;
        block_t data;
    } beat_t;

endpackage

// File: rtl/aes_cbc_ctrl_if.sv
// Block streams, key/IV controls and AES core request/response for aes_cbc_ctrl.
// CORE_ENCDEC uses the MODE_DEC polarity: 0 = encrypt, 1 = decrypt.
interface aes_cbc_ctrl_if;
    import aes_pkg::*;

    logic   MODE_DEC;
    block_t KEY;
    block_t IV;
    logic   IV_LOAD;

    logic   IN_VALID;
    logic   IN_READY;
    block_t IN_DATA;
    logic   IN_LAST;

    logic   OUT_VALID;
    logic   OUT_READY;
    block_t OUT_DATA;
    logic   OUT_LAST;

    logic   CORE_START;
    logic   CORE_ENCDEC;
    block_t CORE_KEY;
    block_t CORE_TEXTIN;
    logic   CORE_DONE;
    block_t CORE_TEXTOUT;

    logic   BUSY;
    logic   ERR_TIMEOUT;

    // Controller side.
    modport slave (
        input  MODE_DEC, KEY, IV, IV_LOAD,
        input  IN_VALID, IN_DATA, IN_LAST,
        output IN_READY,
        output OUT_VALID, OUT_DATA, OUT_LAST,
        input  OUT_READY,
        output CORE_START, CORE_ENCDEC, CORE_KEY, CORE_TEXTIN,
        input  CORE_DONE, CORE_TEXTOUT,
        output BUSY, ERR_TIMEOUT
    );

    // Environment side (block source, sink and AES core).
    modport master (
        output MODE_DEC, KEY, IV, IV_LOAD,
        output IN_VALID, IN_DATA, IN_LAST,
        input  IN_READY,
        input  OUT_VALID, OUT_DATA, OUT_LAST,
        output OUT_READY,
        input  CORE_START, CORE_ENCDEC, CORE_KEY, CORE_TEXTIN,
        output CORE_DONE, CORE_TEXTOUT,
        input  BUSY, ERR_TIMEOUT
    );

endinterface

// File: rtl/aes_done_watchdog.sv
// Counts cycles since CORE_START and flags when the core has not answered in time.
module aes_done_watchdog
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic start_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q is the number of cycles elapsed since CORE_START, the start cycle counting as one.
    assign expire_c = run_i && !start_i && !clear_i
                      && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Start reloads, a core answer parks the counter, waiting advances it.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CNT_W'(1);
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller around an external single-block AES core; one block in flight.
module aes_cbc_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic          CLK,
    input  logic          nRST,
    aes_cbc_ctrl_if.slave bus
);

    state_e state_q, state_d;
    block_t chain_q, chain_d;
    block_t core_textin_q, core_textin_d;
    block_t core_key_q, core_key_d;
    logic   core_encdec_q, core_encdec_d;
    logic   core_start_q, core_start_d;
    logic   last_q, last_d;
    beat_t  out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   busy_q, busy_d;
    logic   err_timeout_q, err_timeout_d;
    logic   core_done_c;
    logic   wd_expire_c;

    assign core_done_c = bus.CORE_DONE && (state_q == ST_WAIT);

    aes_done_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .start_i  (core_start_q),
        .clear_i  (core_done_c),
        .run_i    (state_q == ST_WAIT),
        .expire_c (wd_expire_c)
    );

    // Next state, datapath updates and registered output flags.
    always_comb begin
        state_d       = state_q;
        chain_d       = chain_q;
        core_textin_d = core_textin_q;
        core_key_d    = core_key_q;
        core_encdec_d = core_encdec_q;
        last_d        = last_q;
        out_d         = out_q;
        err_timeout_d = err_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                // IV load lands before a coincident block so that block chains from it.
                if (bus.IV_LOAD) begin
                    chain_d       = bus.IV;
                    err_timeout_d = 1'b0;
                end
                if (bus.IN_VALID) begin
                    state_d       = ST_ISSUE;
                    core_key_d    = bus.KEY;
                    core_encdec_d = bus.MODE_DEC;
                    last_d        = bus.IN_LAST;
                    core_textin_d = bus.MODE_DEC ? bus.IN_DATA : (bus.IN_DATA ^ chain_d);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done_c) begin
                    state_d    = ST_OUTPUT;
                    out_d.last = last_q;
                    // Decrypt chains on the ciphertext, which is exactly what the core was fed.
                    if (core_encdec_q) begin
                        out_d.data = bus.CORE_TEXTOUT ^ chain_q;
                        chain_d    = core_textin_q;
                    end else begin
                        out_d.data = bus.CORE_TEXTOUT;
                        chain_d    = bus.CORE_TEXTOUT;
                    end
                end else if (wd_expire_c) begin
                    state_d       = ST_ERROR;
                    err_timeout_d = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (bus.OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (bus.IV_LOAD) begin
                    state_d       = ST_IDLE;
                    chain_d       = bus.IV;
                    err_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_start_d = (state_d == ST_ISSUE);
        out_valid_d  = (state_d == ST_OUTPUT);
        in_ready_d   = (state_d == ST_IDLE);
        busy_d       = state_d inside {ST_ISSUE, ST_WAIT, ST_OUTPUT};
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            chain_q       <= '0;
            core_textin_q <= '0;
            core_key_q    <= '0;
            core_encdec_q <= 1'b0;
            core_start_q  <= 1'b0;
            last_q        <= 1'b0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            chain_q       <= chain_d;
            core_textin_q <= core_textin_d;
            core_key_q    <= core_key_d;
            core_encdec_q <= core_encdec_d;
            core_start_q  <= core_start_d;
            last_q        <= last_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.IN_READY    = in_ready_q;
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT_DATA    = out_q.data;
    assign bus.OUT_LAST    = out_q.last;
    assign bus.CORE_START  = core_start_q;
    assign bus.CORE_ENCDEC = core_encdec_q;
    assign bus.CORE_KEY    = core_key_q;
    assign bus.CORE_TEXTIN = core_textin_q;
    assign bus.BUSY        = busy_q;
    assign bus.ERR_TIMEOUT = err_timeout_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl with a table-driven AES core model (FIPS-197 / SP800-38A vectors).
module tb_aes_cbc_ctrl;
    import aes_pkg::*;

    localparam block_t K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam block_t CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam block_t K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t IV1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam block_t P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam block_t X1  = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam block_t X2  = 128'hd86421fb9f1a1eda505ee1375746972c;
    localparam block_t C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam block_t C2  = 128'h5086cb9b507219ee95db113a917678b2;

    logic CLK = 1'b0;
    logic nRST;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    int   core_lat = 2;
    bit   core_mute = 1'b0;
    int   start_cnt = 0;
    int   start_cyc = -1;
    int   done_cyc = -1;

    aes_cbc_ctrl_if bus ();

    aes_cbc_ctrl #(
        .TIMEOUT_CYCLES (63)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Known single-block AES results; anything else returns an easily recognised filler.
    function automatic block_t core_lookup(input block_t key, input logic dec, input block_t txt);
        if (!dec && key == K0 && txt == PT0) return CT0;
        if (!dec && key == K1 && txt == X1)  return C1;
        if (!dec && key == K1 && txt == X2)  return C2;
        if ( dec && key == K1 && txt == C1)  return X1;
        if ( dec && key == K1 && txt == C2)  return X2;
        return ~txt;
    endfunction

    // AES core model: answers core_lat cycles after CORE_START with a one-cycle CORE_DONE.
    initial begin
        int     pend;
        block_t res;
        pend = 0;
        res  = '0;
        bus.CORE_DONE    = 1'b0;
        bus.CORE_TEXTOUT = '0;
        forever begin
            @(negedge CLK);
            bus.CORE_DONE = 1'b0;
            if (bus.CORE_START === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
                if (!core_mute) begin
                    pend = core_lat;
                    res  = core_lookup(bus.CORE_KEY, bus.CORE_ENCDEC, bus.CORE_TEXTIN);
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.CORE_DONE    = 1'b1;
                    bus.CORE_TEXTOUT = res;
                    done_cyc         = cyc;
                end
            end
        end
    end

    task automatic iv_load(input block_t iv);
        bus.IV      = iv;
        bus.IV_LOAD = 1'b1;
        @(negedge CLK);
        bus.IV_LOAD = 1'b0;
    endtask

    // Returns at the negedge after the input handshake edge (the CORE_START cycle).
    task automatic send_block(input block_t data, input logic last, input logic dec, output bit ok);
        ok = 1'b0;
        bus.IN_DATA  = data;
        bus.IN_LAST  = last;
        bus.MODE_DEC = dec;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.IN_READY === 1'b1) ok = 1'b1;
            @(negedge CLK);
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output int vcyc);
        ok   = 1'b0;
        vcyc = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.OUT_VALID === 1'b1) begin
                ok   = 1'b1;
                vcyc = cyc;
            end else begin
                @(negedge CLK);
            end
        end
    endtask

    task automatic take_output();
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        total_cnt++; if ({bus.OUT_VALID, bus.OUT_LAST, bus.CORE_START, bus.CORE_ENCDEC, bus.BUSY, bus.ERR_TIMEOUT} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {bus.OUT_VALID, bus.OUT_LAST, bus.CORE_START, bus.CORE_ENCDEC, bus.BUSY, bus.ERR_TIMEOUT}); else pass_cnt++;
        nRST = 1'b1;
        @(negedge CLK);
        total_cnt++; if (bus.IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.IN_READY); else pass_cnt++;
        total_cnt++; if ({bus.OUT_DATA, bus.CORE_TEXTIN} !== 256'h0)
            $display("FAIL reset_data: out %h textin %h want 0", bus.OUT_DATA, bus.CORE_TEXTIN); else pass_cnt++;
    endtask

    task automatic test_fips_enc();
        bit ok;
        int vc;
        iv_load('0);
        bus.KEY = K0;
        send_block(PT0, 1'b0, 1'b0, ok);
        total_cnt++; if (!ok || bus.CORE_START !== 1'b1) $display("FAIL fips_start: hs %0d start %b want hs 1 start 1", ok, bus.CORE_START); else pass_cnt++;
        total_cnt++; if (bus.CORE_TEXTIN !== PT0) $display("FAIL fips_textin: got %h want %h", bus.CORE_TEXTIN, PT0); else pass_cnt++;
        total_cnt++; if (bus.CORE_KEY !== K0 || bus.CORE_ENCDEC !== 1'b0)
            $display("FAIL fips_key: got %h/%b want %h/0", bus.CORE_KEY, bus.CORE_ENCDEC, K0); else pass_cnt++;
        wait_out(ok, vc);
        total_cnt++; if (!ok || vc != done_cyc + 1) $display("FAIL fips_done_to_valid: valid cyc %0d want %0d", vc, done_cyc + 1); else pass_cnt++;
        total_cnt++; if (bus.OUT_DATA !== CT0 || bus.OUT_LAST !== 1'b0 || bus.BUSY !== 1'b1)
            $display("FAIL fips_out: got %h last %b busy %b want %h last 0 busy 1", bus.OUT_DATA, bus.OUT_LAST, bus.BUSY, CT0); else pass_cnt++;
        take_output();
        total_cnt++; if ({bus.IN_READY, bus.OUT_VALID, bus.BUSY} !== 3'b100)
            $display("FAIL fips_release: ready/valid/busy %b want 100", {bus.IN_READY, bus.OUT_VALID, bus.BUSY}); else pass_cnt++;
    endtask

    task automatic test_cbc_enc();
        bit ok;
        int vc;
        iv_load(IV1);
        bus.KEY = K1;
        send_block(P1, 1'b0, 1'b0, ok);
        total_cnt++; if (!ok || bus.CORE_TEXTIN !== X1) $display("FAIL enc1_textin: got %h want %h", bus.CORE_TEXTIN, X1); else pass_cnt++;
        bus.KEY = ~K1;
        @(negedge CLK);
        total_cnt++; if (bus.CORE_KEY !== K1) $display("FAIL enc1_key_held: got %h want %h", bus.CORE_KEY, K1); else pass_cnt++;
        bus.KEY = K1;
        wait_out(ok, vc);
        total_cnt++; if (!ok || bus.OUT_DATA !== C1 || bus.OUT_LAST !== 1'b0)
            $display("FAIL enc1_out: got %h last %b want %h last 0", bus.OUT_DATA, bus.OUT_LAST, C1); else pass_cnt++;
        take_output();
        send_block(P2, 1'b1, 1'b0, ok);
        total_cnt++; if (!ok || bus.CORE_TEXTIN !== X2) $display("FAIL enc2_textin: got %h want %h", bus.CORE_TEXTIN, X2); else pass_cnt++;
        wait_out(ok, vc);
        total_cnt++; if (!ok || bus.OUT_DATA !== C2 || bus.OUT_LAST !== 1'b1)
            $display("FAIL enc2_out: got %h last %b want %h last 1", bus.OUT_DATA, bus.OUT_LAST, C2); else pass_cnt++;
        take_output();
    endtask

    task automatic test_cbc_dec();
        bit ok;
        int vc;
        iv_load(IV1);
        bus.KEY = K1;
        send_block(C1, 1'b0, 1'b1, ok);
        total_cnt++; if (!ok || bus.CORE_TEXTIN !== C1 || bus.CORE_ENCDEC !== 1'b1)
            $display("FAIL dec1_textin: got %h/%b want %h/1", bus.CORE_TEXTIN, bus.CORE_ENCDEC, C1); else pass_cnt++;
        wait_out(ok, vc);
        total_cnt++; if (!ok || bus.OUT_DATA !== P1 || bus.OUT_LAST !== 1'b0)
            $display("FAIL dec1_out: got %h last %b want %h last 0", bus.OUT_DATA, bus.OUT_LAST, P1); else pass_cnt++;
        take_output();
        send_block(C2, 1'b1, 1'b1, ok);
        wait_out(ok, vc);
        total_cnt++; if (!ok || bus.OUT_DATA !== P2 || bus.OUT_LAST !== 1'b1)
            $display("FAIL dec2_out: got %h last %b want %h last 1", bus.OUT_DATA, bus.OUT_LAST, P2); else pass_cnt++;
        take_output();
    endtask

    task automatic test_iv_collide();
        bit ok;
        int vc;
        bus.KEY     = K1;
        bus.IV      = IV1;
        bus.IV_LOAD = 1'b1;
        send_block(P1, 1'b0, 1'b0, ok);
        bus.IV_LOAD = 1'b0;
        total_cnt++; if (!ok || bus.CORE_TEXTIN !== X1) $display("FAIL collide_textin: got %h want %h", bus.CORE_TEXTIN, X1); else pass_cnt++;
        wait_out(ok, vc);
        total_cnt++; if (!ok || bus.OUT_DATA !== C1) $display("FAIL collide_out: got %h want %h", bus.OUT_DATA, C1); else pass_cnt++;
        take_output();
    endtask

    task automatic test_stall();
        bit ok;
        bit stable;
        int vc;
        int starts;
        iv_load('0);
        bus.KEY = K0;
        send_block(PT0, 1'b1, 1'b0, ok);
        wait_out(ok, vc);
        starts = start_cnt;
        total_cnt++; if (!ok || bus.OUT_DATA !== CT0) $display("FAIL stall_out: got %h want %h", bus.OUT_DATA, CT0); else pass_cnt++;
        stable       = 1'b1;
        bus.IN_DATA  = '0;
        bus.IN_VALID = 1'b1;
        bus.IV       = '1;
        for (int i = 0; i < 20; i++) begin
            bus.IV_LOAD = (i == 5);
            @(negedge CLK);
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== CT0 || bus.OUT_LAST !== 1'b1 || bus.IN_READY !== 1'b0) stable = 1'b0;
        end
        bus.IV_LOAD  = 1'b0;
        bus.IN_VALID = 1'b0;
        total_cnt++; if (!stable) $display("FAIL stall_stable: output changed or IN_READY rose during 20-cycle stall"); else pass_cnt++;
        total_cnt++; if (start_cnt != starts) $display("FAIL stall_starts: got %0d extra CORE_START cycles want 0", start_cnt - starts); else pass_cnt++;
        take_output();
        send_block('0, 1'b0, 1'b0, ok);
        total_cnt++; if (!ok || bus.CORE_TEXTIN !== CT0) $display("FAIL chain_continue: got %h want %h", bus.CORE_TEXTIN, CT0); else pass_cnt++;
        wait_out(ok, vc);
        take_output();
    endtask

    task automatic test_timeout();
        bit ok;
        int vc;
        int err_cyc;
        core_mute = 1'b1;
        iv_load(IV1);
        bus.KEY = K1;
        send_block(P1, 1'b0, 1'b0, ok);
        err_cyc = -1;
        for (int i = 0; i < 100 && err_cyc < 0; i++) begin
            if (bus.ERR_TIMEOUT === 1'b1) err_cyc = cyc;
            else @(negedge CLK);
        end
        total_cnt++; if (err_cyc != start_cyc + 63) $display("FAIL timeout_cycle: err at %0d want %0d", err_cyc, start_cyc + 63); else pass_cnt++;
        repeat (5) @(negedge CLK);
        total_cnt++; if ({bus.ERR_TIMEOUT, bus.IN_READY, bus.OUT_VALID, bus.BUSY} !== 4'b1000)
            $display("FAIL timeout_error_state: err/ready/valid/busy %b want 1000", {bus.ERR_TIMEOUT, bus.IN_READY, bus.OUT_VALID, bus.BUSY}); else pass_cnt++;
        core_mute = 1'b0;
        iv_load(IV1);
        total_cnt++; if ({bus.ERR_TIMEOUT, bus.IN_READY} !== 2'b01)
            $display("FAIL timeout_recover: err/ready %b want 01", {bus.ERR_TIMEOUT, bus.IN_READY}); else pass_cnt++;
        send_block(P1, 1'b0, 1'b0, ok);
        wait_out(ok, vc);
        total_cnt++; if (!ok || bus.OUT_DATA !== C1) $display("FAIL timeout_next_block: got %h want %h", bus.OUT_DATA, C1); else pass_cnt++;
        take_output();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit quiet;
        int starts;
        core_lat = 8;
        iv_load('0);
        bus.KEY = K0;
        send_block(PT0, 1'b1, 1'b0, ok);
        repeat (3) @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        total_cnt++; if ({bus.OUT_VALID, bus.BUSY, bus.CORE_START, bus.ERR_TIMEOUT, bus.OUT_LAST} !== 5'b0 || bus.CORE_TEXTIN !== '0)
            $display("FAIL midreset_values: flags %b textin %h want 00000 / 0", {bus.OUT_VALID, bus.BUSY, bus.CORE_START, bus.ERR_TIMEOUT, bus.OUT_LAST}, bus.CORE_TEXTIN); else pass_cnt++;
        nRST = 1'b1;
        starts = start_cnt;
        quiet  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b0) quiet = 1'b0;
        end
        total_cnt++; if (!quiet) $display("FAIL midreset_late_done: output or busy seen after reset"); else pass_cnt++;
        total_cnt++; if (start_cnt != starts) $display("FAIL midreset_starts: got %0d extra CORE_START want 0", start_cnt - starts); else pass_cnt++;
        core_lat = 2;
    endtask

    initial begin
        nRST          = 1'b0;
        bus.MODE_DEC  = 1'b0;
        bus.KEY       = '0;
        bus.IV        = '0;
        bus.IV_LOAD   = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.IN_LAST   = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        test_reset();
        test_fips_enc();
        test_cbc_enc();
        test_cbc_dec();
        test_iv_collide();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/aes_cbc_ctrl.md
AES_CBC_CTRL -- requirements
Module: aes_cbc_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 63; max cycles from CORE_START to CORE_DONE before a timeout is declared.
REQ-002 CLK  in  1  clock; all logic on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 MODE_DEC  in  1  0 = CBC encrypt, 1 = CBC decrypt.
REQ-005 KEY  in  128  cipher key, passed to the core unchanged.
REQ-006 IV  in  128  initial chaining value.
REQ-007 IV_LOAD  in  1  one-cycle pulse; loads IV into the chain register and clears ERR_TIMEOUT.
REQ-008 IN_VALID / IN_READY  in / out  1 / 1  input block handshake.
REQ-009 IN_DATA, IN_LAST  in  128, 1  input block (bit 127 = first byte); last-block flag.
REQ-010 OUT_VALID / OUT_READY  out / in  1 / 1  output block handshake.
REQ-011 OUT_DATA, OUT_LAST  out  128, 1  result block; last flag copied from the input.
REQ-012 CORE_START, CORE_ENCDEC, CORE_KEY, CORE_TEXTIN  out  1, 1, 128, 128  drive the AES core request side.
REQ-013 CORE_DONE, CORE_TEXTOUT  in  1, 128  AES core one-cycle completion pulse and result.
REQ-014 BUSY, ERR_TIMEOUT  out  1, 1  block in flight; sticky timeout flag.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, OUTPUT, ERROR.
REQ-016 IDLE: IN_READY = 1; an IN_VALID & IN_READY handshake latches IN_DATA, IN_LAST, MODE_DEC and KEY, and the FSM moves to ISSUE.
REQ-017 ISSUE: CORE_START is high for exactly one cycle; the FSM then moves to WAIT.
REQ-018 Encrypt: CORE_TEXTIN = IN_DATA XOR chain; OUT_DATA = CORE_TEXTOUT; chain <= CORE_TEXTOUT.
REQ-019 Decrypt: CORE_TEXTIN = IN_DATA; OUT_DATA = CORE_TEXTOUT XOR chain; chain <= the latched IN_DATA.
REQ-020 CORE_TEXTIN, CORE_KEY and CORE_ENCDEC are registered and held stable from ISSUE until CORE_DONE.
REQ-021 WAIT: on CORE_DONE, OUT_DATA is registered, the chain is updated and the FSM moves to OUTPUT the next cycle; CORE_DONE outside WAIT is ignored.
REQ-022 OUTPUT: OUT_VALID = 1 with OUT_DATA and OUT_LAST stable until OUT_READY; on the handshake the FSM returns to IDLE.
REQ-023 Per-block overhead: from input handshake to CORE_START is 1 cycle; from CORE_DONE to OUT_VALID is 1 cycle; with OUT_READY = 1, IN_READY returns 1 cycle after the output handshake.
REQ-024 IN_READY = 0 in every state except IDLE; exactly one block is in flight.
REQ-025 Timeout counter is cleared at CORE_START and increments in WAIT; reaching TIMEOUT_CYCLES without CORE_DONE sets ERR_TIMEOUT and enters ERROR.
REQ-026 ERROR: IN_READY = 0, OUT_VALID = 0; only IV_LOAD (or reset) returns the FSM to IDLE.
REQ-027 IV_LOAD is honoured in IDLE and ERROR only; in other states it is ignored.
REQ-028 IV_LOAD coinciding with an input handshake in IDLE: the IV loads first, and that block uses the new IV.
REQ-029 After an output handshake with OUT_LAST = 1, the chain is held; the next message requires IV_LOAD, otherwise chaining continues.
REQ-030 BUSY = 1 in ISSUE, WAIT and OUTPUT.

Reset
REQ-031 nRST low sets: FSM to IDLE; chain, OUT_DATA and CORE_TEXTIN to 0; OUT_VALID, OUT_LAST, CORE_START, CORE_ENCDEC, BUSY and ERR_TIMEOUT to 0; IN_READY to 1 after release.
REQ-032 Reset mid-block drops the block silently; no output or CORE_START is issued for it after release.

Structure
REQ-033 Package aes_pkg holds: the FSM state encoding, the 128-bit block width constant, and the TIMEOUT_CYCLES default.
REQ-034 The AES core is external and is not instantiated inside this block.
REQ-035 One sub-module, aes_done_watchdog (counter with start/clear/expire), implements REQ-025.

Verification
REQ-036 Encrypt, IV = 0, KEY = 000102..0f, IN_DATA = 00112233445566778899aabbccddeeff -> OUT_DATA = 69c4e0d86a7b0430d8cdb78070b4c55a, with CORE_START one cycle after the input handshake.
REQ-037 Encrypt, KEY = 2b7e151628aed2a6abf7158809cf4f3c, IV = 000102..0f, blocks 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 (second with LAST) -> 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2, OUT_LAST set on the second.
REQ-038 Decrypt, same key and IV, the two ciphertexts from REQ-037 -> the original two plaintexts in order.
REQ-039 Hold OUT_READY = 0 for 20 cycles -> OUT_VALID and OUT_DATA stable, IN_READY = 0, no second CORE_START.
REQ-040 Core model never asserts CORE_DONE -> ERR_TIMEOUT = 1 exactly 63 cycles after CORE_START and IN_READY = 0; then IV_LOAD -> IDLE, ERR_TIMEOUT = 0.
REQ-041 nRST pulsed in WAIT -> all outputs at reset values; a later late CORE_DONE produces no output.
